// File: rtl/rstack_pkg.sv
// Shared defaults and the operation encoding for the return-stack controller.
package rstack_pkg;
  localparam int RS_WIDTH      = 4;
  localparam int RS_SIZE       = 16;
  localparam int RS_DATA_WIDTH = 13;

  typedef enum logic [1:0] {NOP, PUSH, POP, REPLACE} op_e;
endpackage

// File: rtl/rstack_ctrl.sv
// Return-stack pointer/depth controller driving an external async-read memory.
// Define RSTACK_GUARD_EN to reject overflow/underflow and raise a sticky err.
module rstack_ctrl
  import rstack_pkg::*;
#(
  parameter int WIDTH      = RS_WIDTH,
  parameter int SIZE       = RS_SIZE,
  parameter int DATA_WIDTH = RS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top,
  output logic [WIDTH:0]        depth,
  output logic                  empty,
  output logic                  full,
  output logic                  err,
  output logic [WIDTH-1:0]      mem_dout_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_din_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);
  localparam logic [WIDTH-1:0] SP_ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   DEP_ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   DEP_MAX = (WIDTH+1)'(SIZE);

  logic [WIDTH-1:0] sp, sp_m1;
  logic [WIDTH:0]   depth_q;
  logic             is_empty, is_full;
  logic             push_ok, pop_ok;
  op_e              op;

  assign sp_m1    = sp - SP_ONE;
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEP_MAX);

  // push+pop on an empty stack degrades to a plain push
  always_comb begin
    op = NOP;
    if (push && pop && !is_empty) op = REPLACE;
    else if (push)                op = PUSH;
    else if (pop)                 op = POP;
  end

`ifdef RSTACK_GUARD_EN
  logic err_q;
  assign push_ok = (op == PUSH) && !is_full;
  assign pop_ok  = (op == POP) && !is_empty;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset)                                     err_q <= 1'b0;
    else if ((op == PUSH && is_full) || (pop && is_empty)) err_q <= 1'b1;
  end
`else
  assign push_ok = (op == PUSH);
  assign pop_ok  = (op == POP);
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sp      <= '0;
      depth_q <= '0;
    end else if (push_ok) begin
      sp <= sp + SP_ONE;
      // full push without guard overwrites the oldest entry; depth saturates
      if (!is_full) depth_q <= depth_q + DEP_ONE;
    end else if (pop_ok) begin
      sp <= sp_m1;
      if (!is_empty) depth_q <= depth_q - DEP_ONE;
    end
  end

  assign mem_we        = !reset && (push_ok || op == REPLACE);
  assign mem_din_addr  = (op == REPLACE) ? sp_m1 : sp;
  assign mem_din       = push_data;
  assign mem_dout_addr = sp_m1;
  assign top           = is_empty ? '0 : mem_dout;
  assign depth         = depth_q;
  assign empty         = is_empty;
  assign full          = is_full;
endmodule

// File: tb/tb_rstack_ctrl.sv
// Directed scoreboard bench for rstack_ctrl with a behavioural async-read memory.
module tb_rstack_ctrl;
  localparam int NC = -1;
`ifdef RSTACK_GUARD_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1, push = 1'b0, pop = 1'b0;
  logic [12:0] push_data = '0;
  logic [12:0] top, mem_dout, mem_din;
  logic [4:0]  depth;
  logic        empty, full, err, mem_we;
  logic [3:0]  mem_dout_addr, mem_din_addr;
  logic [12:0] mem [16];

  always #5 clk = ~clk;

  rstack_ctrl dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .top(top), .depth(depth), .empty(empty), .full(full), .err(err),
    .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout), .mem_we(mem_we),
    .mem_din_addr(mem_din_addr), .mem_din(mem_din)
  );

  always @(posedge clk) if (mem_we) mem[mem_din_addr] <= mem_din;
  assign mem_dout = mem[mem_dout_addr];

  typedef struct {
    int id; int top; int dep; int err; int we; int wa; int din;
  } exp_t;
  exp_t q[$];
  int   nid = 0;
  int   errors = 0, checks = 0;

  task automatic chk(input int id, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", id, nm, act, exp);
    end
  endtask

  // expected values describe what is observable during the driven cycle
  task automatic cyc(input logic r, ps, pp, input int d,
                     input int etop, edep, eerr, ewe, ewa);
    @(posedge clk); #1;
    reset = r; push = ps; pop = pp; push_data = 13'(d);
    q.push_back('{nid, etop, edep, eerr, ewe, ewa, d});
    nid++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.top >= 0) chk(e.id, "top", int'(top), e.top);
      if (e.dep >= 0) begin
        chk(e.id, "depth", int'(depth), e.dep);
        chk(e.id, "empty", int'(empty), int'(e.dep == 0));
        chk(e.id, "full",  int'(full),  int'(e.dep == 16));
      end
      if (e.err >= 0) chk(e.id, "err", int'(err), e.err);
      if (e.we >= 0) begin
        chk(e.id, "mem_we", int'(mem_we), e.we);
        if (e.we == 1) chk(e.id, "mem_din", int'(mem_din), e.din);
      end
      if (e.wa >= 0) chk(e.id, "mem_din_addr", int'(mem_din_addr), e.wa);
    end
  end

  initial begin
    // reset, then three calls
    cyc(1, 0, 0, 0,      NC, NC, NC, 0, NC);
    cyc(0, 0, 0, 0,      0, 0, 0, 0, NC);
    cyc(0, 1, 0, 'h0A1,  0, 0, 0, 1, 0);
    cyc(0, 1, 0, 'h0B2,  'h0A1, 1, 0, 1, 1);
    cyc(0, 1, 0, 'h0C3,  'h0B2, 2, 0, 1, 2);
    cyc(0, 0, 0, 0,      'h0C3, 3, 0, 0, NC);
    // three returns, top valid in the pop cycle
    cyc(0, 0, 1, 0,      'h0C3, 3, 0, 0, NC);
    cyc(0, 0, 1, 0,      'h0B2, 2, 0, 0, NC);
    cyc(0, 0, 1, 0,      'h0A1, 1, 0, 0, NC);
    cyc(0, 0, 0, 0,      0, 0, 0, 0, NC);
    // replace top
    cyc(0, 1, 0, 'h00F,  0, 0, 0, 1, 0);
    cyc(0, 1, 0, 'h010,  'h00F, 1, 0, 1, 1);
    cyc(0, 1, 1, 'h1FF,  'h010, 2, 0, 1, 1);
    cyc(0, 0, 0, 0,      'h1FF, 2, 0, 0, NC);
    cyc(0, 0, 1, 0,      'h1FF, 2, 0, 0, NC);
    cyc(0, 0, 1, 0,      'h00F, 1, 0, 0, NC);
    cyc(0, 0, 0, 0,      0, 0, 0, 0, NC);
    // fill to 16, then 17th push
    cyc(1, 0, 0, 0,      NC, NC, NC, 0, NC);
    for (int i = 1; i <= 16; i++) cyc(0, 1, 0, i, i - 1, i - 1, 0, 1, i - 1);
    cyc(0, 1, 0, 17,     16, 16, 0, G ? 0 : 1, G ? NC : 0);
    cyc(0, 0, 0, 0,      G ? 16 : 17, 16, G, 0, NC);
    // push+pop on empty acts as push
    cyc(1, 0, 0, 0,      NC, NC, NC, 0, NC);
    cyc(0, 1, 1, 'h055,  0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0,      'h055, 1, G, 0, NC);
    // pop on empty, then reset colliding with push
    cyc(1, 0, 0, 0,      NC, NC, NC, 0, NC);
    cyc(0, 0, 1, 0,      0, 0, 0, 0, NC);
    cyc(0, 1, 0, 'h077,  0, 0, G, 1, G ? 0 : 15);
    cyc(1, 1, 0, 'h099,  NC, NC, NC, 0, NC);
    cyc(0, 0, 0, 0,      0, 0, 0, 0, NC);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
